// File: rtl/aes_operand_loader_pkg.sv
// Package aes_ld_pkg: shared definitions for the AES operand loader.
//   ld_state_e    - loader FSM state encoding
//   HALF_BITS_DEF - default bits per lane per frame
//   OPERAND_W     - default operand width (key / plaintext)
package aes_ld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } ld_state_e;

  localparam int unsigned HALF_BITS_DEF = 64;
  localparam int unsigned OPERAND_W     = 2 * HALF_BITS_DEF;

endpackage

// File: rtl/aes_operand_loader_if.sv
// Output handoff bundle between the operand loader and aescipher.
//   key_out/data_out - buffered 2*HALF_BITS operands
//   out_valid        - operands hold a complete frame
//   out_ready        - consumer accepts the frame
// master: loader side; slave: consumer side.
interface aes_operand_loader_if
  import aes_ld_pkg::*;
#(
  parameter int unsigned HALF_BITS = HALF_BITS_DEF
) ();

  logic [2*HALF_BITS-1:0] key_out;
  logic [2*HALF_BITS-1:0] data_out;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output key_out,
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  key_out,
    input  data_out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/aes_operand_loader_lane_deser.sv
// lane_deser: one pair of serial lanes into a 2*HALF_BITS shadow word.
//   clk, rst       - clock, async active-low reset
//   we             - write the lane bits at idx this edge
//   idx            - sample index (0..HALF_BITS-1)
//   lo_bit, hi_bit - lane bits for word[idx] and word[idx+HALF_BITS]
//   word_q         - stored shadow word
//   word_d         - shadow word including this cycle's write (used for
//                    same-edge handoff of the final sample)
module lane_deser
  import aes_ld_pkg::*;
#(
  parameter int unsigned HALF_BITS = HALF_BITS_DEF,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [CNT_W-1:0]       idx,
  input  logic                   lo_bit,
  input  logic                   hi_bit,
  output logic [2*HALF_BITS-1:0] word_q,
  output logic [2*HALF_BITS-1:0] word_d
);

  logic [HALF_BITS-1:0] lo_q, lo_d;
  logic [HALF_BITS-1:0] hi_q, hi_d;

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    for (int unsigned i = 0; i < HALF_BITS; i++) begin
      if (we && (idx == CNT_W'(i))) begin
        lo_d[i] = lo_bit;
        hi_d[i] = hi_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign word_q = {hi_q, lo_q};
  assign word_d = {hi_d, lo_d};

endmodule

// File: rtl/aes_operand_loader.sv
// aes_operand_loader: deserialises key1/key2/data1/data2 lanes (LSB first)
// into a 128-bit key and plaintext, double-buffered behind a valid/ready
// handoff to aescipher.
//   clk, rst            - clock, async active-low reset
//   load_start          - frame start pulse
//   bit_en              - lane sample strobe
//   key1/key2/data1/data2 - serial lanes (low half / high half)
//   busy                - FSM not IDLE (registered)
//   load_done           - pulse when a frame enters the output buffer
//   frame_err           - pulse on load_start during SHIFT or HOLD
//   out_if              - key_out/data_out/out_valid/out_ready handoff
module aes_operand_loader
  import aes_ld_pkg::*;
#(
  parameter int unsigned HALF_BITS = HALF_BITS_DEF,
  parameter int unsigned CNT_W     = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic load_start,
  input  logic bit_en,
  input  logic key1,
  input  logic key2,
  input  logic data1,
  input  logic data2,
  output logic busy,
  output logic load_done,
  output logic frame_err,
  aes_operand_loader_if.master out_if
);

  localparam int unsigned OPW = 2 * HALF_BITS;

  ld_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]     key_out_q, key_out_d;
  logic [OPW-1:0]     data_out_q, data_out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               load_done_q, load_done_d;
  logic               frame_err_q, frame_err_d;

  logic               wr_en;
  logic               slot_free;
  logic [OPW-1:0]     key_sh_q, key_sh_d;
  logic [OPW-1:0]     data_sh_q, data_sh_d;

  lane_deser #(.HALF_BITS(HALF_BITS), .CNT_W(CNT_W)) u_key_deser (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .idx    (cnt_q),
    .lo_bit (key1),
    .hi_bit (key2),
    .word_q (key_sh_q),
    .word_d (key_sh_d)
  );

  lane_deser #(.HALF_BITS(HALF_BITS), .CNT_W(CNT_W)) u_data_deser (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .idx    (cnt_q),
    .lo_bit (data1),
    .hi_bit (data2),
    .word_q (data_sh_q),
    .word_d (data_sh_d)
  );

  // Output slot can take a frame if empty or being drained this edge.
  assign slot_free = !out_valid_q || out_if.out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_out_d   = key_out_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q && !out_if.out_ready;
    load_done_d = 1'b0;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (load_start) begin
          // Abort and restart; any strobe this cycle is dropped.
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end else if (bit_en) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_W'(HALF_BITS - 1)) begin
            if (slot_free) begin
              // Handoff uses the merged view so the final bits land too.
              key_out_d   = key_sh_d;
              data_out_d  = data_sh_d;
              out_valid_d = 1'b1;
              load_done_d = 1'b1;
              state_d     = ST_IDLE;
              cnt_d       = '0;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        frame_err_d = load_start;
        if (slot_free) begin
          key_out_d   = key_sh_q;
          data_out_d  = data_sh_q;
          out_valid_d = 1'b1;
          load_done_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_out_q   <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_out_q   <= key_out_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_if.key_out   = key_out_q;
  assign out_if.data_out  = data_out_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign load_done        = load_done_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_aes_operand_loader.sv
// Directed testbench for aes_operand_loader.
module tb_aes_operand_loader;

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALT64  = 64'hAAAA_AAAA_AAAA_AAAA;

  logic clk = 1'b0;
  logic rst;
  logic load_start, bit_en, key1, key2, data1, data2;
  logic busy, load_done, frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_operand_loader_if #(.HALF_BITS(64)) bus ();

  aes_operand_loader #(.HALF_BITS(64), .CNT_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bit_en     (bit_en),
    .key1       (key1),
    .key2       (key2),
    .data1      (data1),
    .data2      (data2),
    .busy       (busy),
    .load_done  (load_done),
    .frame_err  (frame_err),
    .out_if     (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic k1, input logic k2, input logic d1, input logic d2);
    bit_en = 1'b1;
    key1 = k1; key2 = k2; data1 = d1; data2 = d2;
    step();
    bit_en = 1'b0;
  endtask

  task automatic start_frame();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load_start = 1'b0; bit_en = 1'b0;
    key1 = 1'b0; key2 = 1'b0; data1 = 1'b0; data2 = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_key",       bus.key_out,   128'h0);
    chk("rst_data",      bus.data_out,  128'h0);
    chk("rst_valid",     bus.out_valid, 1'b0);
    chk("rst_busy",      busy,          1'b0);
    chk("rst_done",      load_done,     1'b0);
    chk("rst_err",       frame_err,     1'b0);
    step();
    rst = 1'b1;
    step();

    // Basic load, back-to-back strobes, out_ready=0
    start_frame();
    chk("basic_busy", busy, 1'b1);
    for (int i = 0; i < 64; i++) begin
      logic b;
      b = i[0];
      strobe(b, 1'b1, 1'b0, b);
      if (i == 62) chk("basic_valid_early", bus.out_valid, 1'b0);
    end
    chk("basic_valid", bus.out_valid, 1'b1);
    chk("basic_done",  load_done,     1'b1);
    chk("basic_key",   bus.key_out,   {ONES64, ALT64});
    chk("basic_data",  bus.data_out,  {ALT64, 64'h0});
    chk("basic_idle",  busy,          1'b0);
    step();
    chk("basic_done_pulse", load_done,     1'b0);
    chk("basic_valid_hold", bus.out_valid, 1'b1);

    // Drain, then gapped strobes every third cycle, all ones
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("drain_valid", bus.out_valid, 1'b0);
    start_frame();
    for (int i = 0; i < 64; i++) begin
      strobe(1'b1, 1'b1, 1'b1, 1'b1);
      if (i == 62) chk("gap_valid_early", bus.out_valid, 1'b0);
      if (i < 63) begin
        step();
        step();
      end
    end
    chk("gap_valid", bus.out_valid, 1'b1);
    chk("gap_done",  load_done,     1'b1);
    chk("gap_key",   bus.key_out,   {ONES64, ONES64});
    chk("gap_data",  bus.data_out,  {ONES64, ONES64});

    // Backpressure: second all-zero frame while first is pending
    start_frame();
    for (int i = 0; i < 64; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_busy",  busy,          1'b1);
    chk("bp_done",  load_done,     1'b0);
    chk("bp_valid", bus.out_valid, 1'b1);
    chk("bp_key",   bus.key_out,   {ONES64, ONES64});
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("bp_hold_err", frame_err,   1'b1);
    chk("bp_hold_key", bus.key_out, {ONES64, ONES64});
    step();
    bus.out_ready = 1'b1;
    step();
    chk("bp_rel_key",   bus.key_out,   128'h0);
    chk("bp_rel_data",  bus.data_out,  128'h0);
    chk("bp_rel_valid", bus.out_valid, 1'b1);
    chk("bp_rel_done",  load_done,     1'b1);
    chk("bp_rel_busy",  busy,          1'b0);
    step();
    chk("bp_accept_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Abort at cnt=20, restart with all ones
    start_frame();
    for (int i = 0; i < 20; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0);
    load_start = 1'b1;
    bit_en = 1'b1;
    key1 = 1'b0; key2 = 1'b0; data1 = 1'b0; data2 = 1'b0;
    step();
    load_start = 1'b0;
    bit_en = 1'b0;
    chk("abort_err",  frame_err, 1'b1);
    chk("abort_busy", busy,      1'b1);
    for (int i = 0; i < 64; i++) begin
      strobe(1'b1, 1'b1, 1'b1, 1'b1);
      if (i == 0)  chk("abort_err_pulse", frame_err, 1'b0);
      if (i == 62) chk("abort_valid_early", bus.out_valid, 1'b0);
    end
    chk("abort_valid", bus.out_valid, 1'b1);
    chk("abort_key",   bus.key_out,   {ONES64, ONES64});
    chk("abort_data",  bus.data_out,  {ONES64, ONES64});

    // Accept-and-refill on the final strobe edge
    start_frame();
    for (int i = 0; i < 63; i++) strobe(1'b1, 1'b0, 1'b0, 1'b1);
    chk("refill_pre_key", bus.key_out, {ONES64, ONES64});
    bus.out_ready = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    chk("refill_valid", bus.out_valid, 1'b1);
    chk("refill_done",  load_done,     1'b1);
    chk("refill_key",   bus.key_out,   {64'h0, ONES64});
    chk("refill_data",  bus.data_out,  {ONES64, 64'h0});

    // Async reset mid-cycle at cnt=40 with out_valid=1
    start_frame();
    for (int i = 0; i < 40; i++) strobe(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_busy",  busy,          1'b0);
    chk("arst_key",   bus.key_out,   128'h0);
    chk("arst_data",  bus.data_out,  128'h0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) strobe(1'b1, 1'b1, 1'b1, 1'b1);
    chk("arst_after_valid", bus.out_valid, 1'b0);
    chk("arst_after_busy",  busy,          1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_operand_loader.md
Name: aes_operand_loader

Overview:
- Upstream stage of the encrypt/stego wrapper. Deserialises the four pad lanes (key1, key2, data1, data2) into the 128-bit key and 128-bit plaintext consumed by aescipher.
- Replaces free-running counter loading with an explicit frame start, a sample strobe, a double buffer and a valid/ready handoff.
- Completion is flagged with a one-cycle pulse.

Parameters:
- HALF_BITS, 64, bits carried per lane per frame; operand width is 2*HALF_BITS.
- CNT_W, 7, counter width; must satisfy 2**CNT_W > HALF_BITS.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- load_start  input  1  frame start request; one-cycle pulse.
- bit_en  input  1  sample strobe; lanes are sampled only when high.
- key1  input  1  key lane, low half.
- key2  input  1  key lane, high half.
- data1  input  1  data lane, low half.
- data2  input  1  data lane, high half.
- key_out  output  2*HALF_BITS  buffered key to aescipher.
- data_out  output  2*HALF_BITS  buffered plaintext to aescipher.
- out_valid  output  1  key_out/data_out hold a complete frame.
- out_ready  input  1  consumer accepts the frame.
- busy  output  1  state is not IDLE.
- load_done  output  1  one-cycle pulse when a frame moves into the output buffer.
- frame_err  output  1  one-cycle pulse when load_start arrives at a bad time.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - Shadow registers and key_out/data_out are all zero.
  - out_valid=0, busy=0, load_done=0, frame_err=0.
- Bit mapping, LSB first. At sample index i (0..HALF_BITS-1):
  - key1 goes to shadow_key[i]; key2 goes to shadow_key[i+HALF_BITS].
  - data1 goes to shadow_data[i]; data2 goes to shadow_data[i+HALF_BITS].
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - load_start=1 moves to SHIFT with cnt=0.
  - bit_en is ignored.
  - Shadow registers are not cleared; every bit is overwritten during the frame.
- SHIFT, bit_en=1 and cnt<HALF_BITS-1: write the four bits at cnt, then cnt++.
- SHIFT, bit_en=1 and cnt==HALF_BITS-1: write the final bits and check the output slot.
  - Slot is free when out_valid=0, or out_valid=1 and out_ready=1 on the same edge.
  - Slot free: on the same edge, copy the full shadow (including the final bits) to key_out/data_out, set out_valid=1, pulse load_done, go to IDLE.
  - Slot busy: go to HOLD.
- SHIFT, bit_en=0: hold; there is no timeout.
- SHIFT, load_start=1: pulse frame_err, abort the frame, restart with cnt=0 and stay in SHIFT. If bit_en is also high that cycle, its bits are discarded.
- HOLD: when the slot is free (rule above), transfer, set out_valid=1, pulse load_done, go to IDLE.
- HOLD, load_start=1: ignored except for a frame_err pulse.
- Output handshake:
  - out_valid=1 and out_ready=1 with no transfer that edge: out_valid goes to 0.
  - Accept and refill on the same edge: out_valid stays 1 with the new data.
  - While out_valid=1 and out_ready=0, key_out/data_out are stable.
- Latency:
  - The last sample edge equals the out_valid rise when the slot is free.
  - Otherwise out_valid rises on the edge the slot frees.
  - Minimum frame period: HALF_BITS strobed cycles plus one load_start cycle.
- IDLE, load_start=1 while out_valid=1: accepted. The new frame shifts into the shadow; the output stays untouched until the handoff.
- busy is registered and goes high the cycle after load_start is accepted.
- rst mid-frame: everything returns to reset values and the partial frame is lost.

Decomposition:
- Package aes_ld_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2);
  - HALF_BITS default;
  - OPERAND_W = 2*HALF_BITS.
- One natural sub-module: lane_deser, instantiated twice (key and data). Each instance holds two HALF_BITS shadow halves written at cnt.
- The FSM, counter and output buffer live in the top.

Test Plan:
- Basic load: rst release; load_start; 64 strobes with key1=i[0], key2=1, data1=0, data2=i[0]; out_ready=0. Required response:
  - key_out = {64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA};
  - data_out = {64'hAAAA_AAAA_AAAA_AAAA, 64'h0};
  - out_valid=1 on the 64th strobe edge, with a single load_done pulse.
- Gapped strobes: bit_en=1 every third cycle, all lanes=1. Required: frame completes after exactly 64 strobes and both outputs equal 128'hFF..FF.
- Backpressure: a frame is pending with out_ready=0; a second frame of all-zero lanes completes. Required: FSM in HOLD, busy=1, key_out unchanged. Raising out_ready then gives key_out=0, out_valid=1 and load_done on that edge.
- Abort: load_start at cnt=20; new frame all-ones. Required: frame_err pulses once; the result is all-ones, with no residue from the first 20 bits.
- Async reset: rst=0 mid-cycle at cnt=40 with out_valid=1. Required: out_valid, busy and the outputs clear immediately, without waiting for a clock edge.
- Accept-and-refill: out_ready=1 on the final-strobe edge while out_valid=1. Required: out_valid stays 1, outputs take the new frame, load_done=1.
